// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: bus between the issue controller and the combinational 64-bit ALU.
// The master drives operands and the control code; the slave (the ALU) returns R and ZERO.
interface alu_issue_ctrl_if #(
    parameter int WIDTH = 64
);
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] alu_r;
    logic             alu_zero;

    modport master (
        output alu_a,
        output alu_b,
        output alu_ctrl,
        input  alu_r,
        input  alu_zero
    );

    modport slave (
        input  alu_a,
        input  alu_b,
        input  alu_ctrl,
        output alu_r,
        output alu_zero
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: accepts LEGv8 instructions, decodes them to an ALU control code,
// holds the ALU operands stable for one cycle and returns the registered result,
// zero flag, CBZ branch decision and an illegal-opcode flag on a valid/ready handshake.
module alu_issue_ctrl #(
    parameter int WIDTH = 64,
    parameter int OPW   = 11,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   in_opcode,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    alu_issue_ctrl_if.master alu,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_branch,
    output logic             out_illegal,
    output logic [CNT_W-1:0] issue_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_nextState;

    logic [WIDTH-1:0] r_aluA;
    logic [WIDTH-1:0] r_aluB;
    logic [3:0]       r_aluCtrl;
    logic             r_cbz;
    logic [WIDTH-1:0] r_outResult;
    logic             r_outZero;
    logic             r_outBranch;
    logic             r_outIllegal;
    logic [CNT_W-1:0] r_issueCount;

    logic             w_legal;
    logic             w_isCbz;
    logic [3:0]       w_code;

    // Opcode decode: map each recognised LEGv8 opcode to its ALU control code; CBZ passes B through.
    always_comb begin
        w_legal = 1'b1;
        w_isCbz = 1'b0;
        w_code  = 4'b0000;
        casez (in_opcode)
            11'b10001011000: w_code = 4'b0010;
            11'b11001011000: w_code = 4'b0110;
            11'b10001010000: w_code = 4'b0000;
            11'b10101010000: w_code = 4'b0001;
            11'b11111000010: w_code = 4'b0010;
            11'b11111000000: w_code = 4'b0010;
            11'b10110100???: begin
                w_code  = 4'b0111;
                w_isCbz = 1'b1;
            end
            default: w_legal = 1'b0;
        endcase
    end

    // State register; reset returns to IDLE from any state, dropping an in-flight op.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state: legal ops spend one cycle in EXEC, illegal ops go straight to DONE.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_nextState = w_legal ? EXEC : DONE;
                end
            end
            EXEC:    w_nextState = DONE;
            DONE: begin
                if (out_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Handshake outputs follow directly from the current state.
    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
    end

    // Datapath registers: latch operands on accept, capture the ALU result at the end of EXEC.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_aluA       <= '0;
            r_aluB       <= '0;
            r_aluCtrl    <= 4'b0000;
            r_cbz        <= 1'b0;
            r_outResult  <= '0;
            r_outZero    <= 1'b0;
            r_outBranch  <= 1'b0;
            r_outIllegal <= 1'b0;
            r_issueCount <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        if (w_legal) begin
                            r_aluA    <= in_a;
                            r_aluB    <= in_b;
                            r_aluCtrl <= w_code;
                            r_cbz     <= w_isCbz;
                        end else begin
                            r_outResult  <= '0;
                            r_outZero    <= 1'b0;
                            r_outBranch  <= 1'b0;
                            r_outIllegal <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    r_outResult  <= alu.alu_r;
                    r_outZero    <= alu.alu_zero;
                    r_outBranch  <= r_cbz & alu.alu_zero;
                    r_outIllegal <= 1'b0;
                    if (r_issueCount != CNT_MAX) begin
                        r_issueCount <= r_issueCount + CNT_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign alu.alu_a    = r_aluA;
    assign alu.alu_b    = r_aluB;
    assign alu.alu_ctrl = r_aluCtrl;
    assign out_result   = r_outResult;
    assign out_zero     = r_outZero;
    assign out_branch   = r_outBranch;
    assign out_illegal  = r_outIllegal;
    assign issue_count  = r_issueCount;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: drives directed and randomized LEGv8 instructions into alu_issue_ctrl,
// models the ALU as a slave on the bus, and compares every handshake against an
// instruction-level reference model.
module tb_alu_issue_ctrl;

    localparam int WIDTH = 64;
    localparam int OPW   = 11;
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100101;
    localparam logic [10:0] OP_BAD  = 11'b11111111111;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [OPW-1:0]   in_opcode;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic             out_branch;
    logic             out_illegal;
    logic [CNT_W-1:0] issue_count;

    int               errors = 0;
    int               checks = 0;

    logic [3:0]       expCtrl;
    logic [WIDTH-1:0] expA;
    logic [WIDTH-1:0] expB;
    logic [CNT_W-1:0] expCount;

    always #5 clk = ~clk;

    alu_issue_ctrl_if #(.WIDTH(WIDTH)) bus ();

    alu_issue_ctrl #(
        .WIDTH(WIDTH),
        .OPW  (OPW),
        .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_a       (in_a),
        .in_b       (in_b),
        .alu        (bus),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_branch (out_branch),
        .out_illegal(out_illegal),
        .issue_count(issue_count)
    );

    // Combinational ALU sitting on the slave side of the bus.
    always_comb begin
        bus.alu_r = '0;
        case (bus.alu_ctrl)
            4'b0000: bus.alu_r = bus.alu_a & bus.alu_b;
            4'b0001: bus.alu_r = bus.alu_a | bus.alu_b;
            4'b0010: bus.alu_r = bus.alu_a + bus.alu_b;
            4'b0110: bus.alu_r = bus.alu_a - bus.alu_b;
            4'b0111: bus.alu_r = bus.alu_b;
            default: bus.alu_r = '0;
        endcase
        bus.alu_zero = (bus.alu_r == '0);
    end

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Instruction-level meaning of each LEGv8 opcode: what the datapath should compute.
    function automatic void refModel(input logic [10:0] op, input logic [63:0] a, input logic [63:0] b,
                                     output bit legal, output logic [3:0] ctrl,
                                     output logic [63:0] res, output bit isCbz);
        logic [7:0] cbzField;
        legal    = 1'b1;
        isCbz    = 1'b0;
        ctrl     = 4'b0000;
        res      = '0;
        cbzField = op[10:3];
        if (op == OP_ADD) begin
            ctrl = 4'b0010; res = a + b;
        end else if (op == OP_SUB) begin
            ctrl = 4'b0110; res = a - b;
        end else if (op == OP_AND) begin
            ctrl = 4'b0000; res = a & b;
        end else if (op == OP_ORR) begin
            ctrl = 4'b0001; res = a | b;
        end else if (op == OP_LDUR || op == OP_STUR) begin
            ctrl = 4'b0010; res = a + b;
        end else if (cbzField == 8'b10110100) begin
            ctrl = 4'b0111; res = b; isCbz = 1'b1;
        end else begin
            legal = 1'b0;
        end
    endfunction

    // Issue one instruction, hold out_ready low for 'hold' DONE cycles, then retire it.
    task automatic applyStimulus(input logic [10:0] op, input logic [63:0] a, input logic [63:0] b, input int hold);
        bit          legal;
        bit          isCbz;
        logic [3:0]  ctrl;
        logic [63:0] res;
        logic [63:0] expRes;
        bit          expZero;
        bit          expBr;
        bit          expIll;
        refModel(op, a, b, legal, ctrl, res, isCbz);
        in_valid  = 1'b1;
        in_opcode = op;
        in_a      = a;
        in_b      = b;
        checkOutput("in_ready_idle", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = (hold == 0);
        if (legal) begin
            expCtrl = ctrl;
            expA    = a;
            expB    = b;
            checkOutput("exec_ctrl", 64'(bus.alu_ctrl), 64'(expCtrl));
            checkOutput("exec_alu_a", bus.alu_a, expA);
            checkOutput("exec_alu_b", bus.alu_b, expB);
            checkOutput("exec_in_ready", 64'(in_ready), 64'd0);
            checkOutput("exec_out_valid", 64'(out_valid), 64'd0);
            @(posedge clk); #1;
            if (expCount != CNT_MAX) expCount = expCount + 1'b1;
            expRes  = res;
            expZero = (res == '0);
            expBr   = isCbz && expZero;
            expIll  = 1'b0;
        end else begin
            expRes  = '0;
            expZero = 1'b0;
            expBr   = 1'b0;
            expIll  = 1'b1;
        end
        checkOutput("done_valid", 64'(out_valid), 64'd1);
        checkOutput("done_result", out_result, expRes);
        checkOutput("done_zero", 64'(out_zero), 64'(expZero));
        checkOutput("done_branch", 64'(out_branch), 64'(expBr));
        checkOutput("done_illegal", 64'(out_illegal), 64'(expIll));
        checkOutput("done_count", 64'(issue_count), 64'(expCount));
        checkOutput("done_ctrl", 64'(bus.alu_ctrl), 64'(expCtrl));
        checkOutput("done_alu_a", bus.alu_a, expA);
        checkOutput("done_in_ready", 64'(in_ready), 64'd0);
        for (int i = 0; i < hold; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_opcode = 11'($urandom);
            @(posedge clk); #1;
            checkOutput("hold_valid", 64'(out_valid), 64'd1);
            checkOutput("hold_result", out_result, expRes);
            checkOutput("hold_branch", 64'(out_branch), 64'(expBr));
            checkOutput("hold_in_ready", 64'(in_ready), 64'd0);
            checkOutput("hold_ctrl", 64'(bus.alu_ctrl), 64'(expCtrl));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput("retire_valid", 64'(out_valid), 64'd0);
        checkOutput("retire_in_ready", 64'(in_ready), 64'd1);
    endtask

    // Reset arriving while a legal op is in EXEC must drop the op and clear everything.
    task automatic resetDuringExec(input logic [63:0] a, input logic [63:0] b);
        in_valid  = 1'b1;
        in_opcode = OP_ADD;
        in_a      = a;
        in_b      = b;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        reset     = 1'b1;
        @(posedge clk); #1;
        reset     = 1'b0;
        expCtrl   = 4'b0000;
        expA      = '0;
        expB      = '0;
        expCount  = '0;
        checkOutput("rst_exec_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_exec_ctrl", 64'(bus.alu_ctrl), 64'd0);
        checkOutput("rst_exec_alu_a", bus.alu_a, 64'd0);
        checkOutput("rst_exec_count", 64'(issue_count), 64'd0);
        checkOutput("rst_exec_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_exec_result", out_result, 64'd0);
        @(posedge clk); #1;
        checkOutput("rst_exec_still_idle", 64'(out_valid), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [10:0] op;
        logic [63:0] a;
        logic [63:0] b;
        int          pick;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_opcode = '0;
        in_a      = '0;
        in_b      = '0;
        expCtrl   = 4'b0000;
        expA      = '0;
        expB      = '0;
        expCount  = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_ctrl", 64'(bus.alu_ctrl), 64'd0);
        checkOutput("reset_count", 64'(issue_count), 64'd0);
        checkOutput("reset_result", out_result, 64'd0);
        checkOutput("reset_illegal", 64'(out_illegal), 64'd0);

        $display("[TB] directed instructions");
        applyStimulus(OP_ADD, 64'd5, 64'd7, 0);
        applyStimulus(OP_SUB, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        applyStimulus(OP_CBZ, 64'd123, 64'd0, 0);
        applyStimulus(OP_CBZ, 64'd123, 64'd3, 0);
        applyStimulus(OP_BAD, 64'd9, 64'd9, 2);
        applyStimulus(OP_ORR, 64'hF0, 64'h0F, 5);
        applyStimulus(OP_AND, 64'hF0, 64'h0F, 0);
        applyStimulus(OP_LDUR, 64'h1000, 64'hFFFF_FFFF_FFFF_FFF8, 0);
        applyStimulus(OP_STUR, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0);

        $display("[TB] reset during EXEC");
        resetDuringExec(64'd1, 64'd2);

        $display("[TB] randomized instructions");
        for (int n = 0; n < 60; n++) begin
            pick = int'($urandom_range(0, 8));
            case (pick)
                0: op = OP_ADD;
                1: op = OP_SUB;
                2: op = OP_AND;
                3: op = OP_ORR;
                4: op = OP_LDUR;
                5: op = OP_STUR;
                6: op = {8'b10110100, 3'($urandom)};
                7: op = 11'($urandom);
                default: op = OP_BAD;
            endcase
            a = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = '0;
                default: b = {$urandom, $urandom};
            endcase
            applyStimulus(op, a, b, int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
